// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle control unit: state codes,
// datapath mux select encodings and the opcode class used after DECODE.
package mc_ctrl_pkg;

    // Controller states. The numeric codes are visible on state_o and
    // must stay fixed; codes 13-15 are unused.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    // ALU operand B select.
    localparam logic [1:0] SRCB_B     = 2'd0;
    localparam logic [1:0] SRCB_FOUR  = 2'd1;
    localparam logic [1:0] SRCB_IMM   = 2'd2;
    localparam logic [1:0] SRCB_SHIMM = 2'd3;

    // ALU operation select.
    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    // Next-PC source select.
    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Instruction class, produced by the opcode decoder.
    typedef enum logic [2:0] {
        CL_LW   = 3'd0,
        CL_SW   = 3'd1,
        CL_RT   = 3'd2,
        CL_BEQ  = 3'd3,
        CL_BNE  = 3'd4,
        CL_ADDI = 3'd5,
        CL_J    = 3'd6,
        CL_ILL  = 3'd7
    } op_class_t;

    // State entered after DECODE for a given instruction class.
    function automatic state_t decode_target(op_class_t cls);
        state_t nxt;
        case (cls)
            CL_LW, CL_SW:   nxt = S_MEMADR;
            CL_RT:          nxt = S_EXEC;
            CL_BEQ, CL_BNE: nxt = S_BRANCH;
            CL_ADDI:        nxt = S_ADDIEX;
            CL_J:           nxt = S_JUMP;
            default:        nxt = S_TRAP;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier. Anything that does not match a supported
// opcode (including bne when it is disabled) is reported as illegal.
module mc_op_decode
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned         OP_W     = 6,
    parameter logic [OP_W-1:0]     OP_LW    = OP_W'(35),
    parameter logic [OP_W-1:0]     OP_SW    = OP_W'(43),
    parameter logic [OP_W-1:0]     OP_RTYPE = OP_W'(0),
    parameter logic [OP_W-1:0]     OP_BEQ   = OP_W'(4),
    parameter logic [OP_W-1:0]     OP_BNE   = OP_W'(5),
    parameter logic [OP_W-1:0]     OP_ADDI  = OP_W'(8),
    parameter logic [OP_W-1:0]     OP_J     = OP_W'(2),
    parameter bit                  EN_BNE   = 1'b1
) (
    input  logic [OP_W-1:0] op,
    output op_class_t       op_class
);

    // Map the raw opcode to its class; opcodes are distinct so order is irrelevant.
    always_comb begin
        // NOTE: a default assigned before any branch means every path drives
        // op_class, so no latch is inferred.
        op_class = CL_ILL;
        if (op == OP_LW) begin
            op_class = CL_LW;
        end else if (op == OP_SW) begin
            op_class = CL_SW;
        end else if (op == OP_RTYPE) begin
            op_class = CL_RT;
        end else if (op == OP_BEQ) begin
            op_class = CL_BEQ;
        end else if (EN_BNE && (op == OP_BNE)) begin
            op_class = CL_BNE;
        end else if (op == OP_ADDI) begin
            op_class = CL_ADDI;
        end else if (op == OP_J) begin
            op_class = CL_J;
        end
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS-style control unit. Sequences fetch, decode, execute,
// memory and writeback; memory states wait on mem_ready, unknown opcodes
// go through a one-cycle TRAP state that pulses illegal_op.
module mc_ctrl_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned         OP_W     = 6,
    parameter logic [OP_W-1:0]     OP_LW    = OP_W'(35),
    parameter logic [OP_W-1:0]     OP_SW    = OP_W'(43),
    parameter logic [OP_W-1:0]     OP_RTYPE = OP_W'(0),
    parameter logic [OP_W-1:0]     OP_BEQ   = OP_W'(4),
    parameter logic [OP_W-1:0]     OP_BNE   = OP_W'(5),
    parameter logic [OP_W-1:0]     OP_ADDI  = OP_W'(8),
    parameter logic [OP_W-1:0]     OP_J     = OP_W'(2),
    parameter bit                  EN_BNE   = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [OP_W-1:0] OP,
    input  logic            mem_ready,
    output logic            IorD,
    output logic            AluSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ALUOp,
    output logic [1:0]      PCSrc,
    output logic            IRWrite,
    output logic            PCWrite,
    output logic            RegDst,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            Branch,
    output logic            BranchNe,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            illegal_op,
    output logic [3:0]      state_o
);

    state_t    state_q;
    state_t    state_d;
    op_class_t dec_class;
    op_class_t class_q;

    mc_op_decode #(
        .OP_W     (OP_W),
        .OP_LW    (OP_LW),
        .OP_SW    (OP_SW),
        .OP_RTYPE (OP_RTYPE),
        .OP_BEQ   (OP_BEQ),
        .OP_BNE   (OP_BNE),
        .OP_ADDI  (OP_ADDI),
        .OP_J     (OP_J),
        .EN_BNE   (EN_BNE)
    ) u_op_decode (
        .op       (OP),
        .op_class (dec_class)
    );

    // State register plus the instruction class captured during DECODE.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the edge.
        if (rst) begin
            state_q <= S_FETCH;
            // NOTE: class_q is a single control register, not a memory array,
            // so it is reset to a safe value along with the state.
            class_q <= CL_ILL;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                class_q <= dec_class;
            end
        end
    end

    // Next-state and output decode; mem_ready gating is the only Mealy term.
    always_comb begin
        state_d    = state_q;
        IorD       = 1'b0;
        AluSrcA    = 1'b0;
        ALUSrcB    = SRCB_B;
        ALUOp      = ALUOP_ADD;
        PCSrc      = PCSRC_ALU;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        Branch     = 1'b0;
        BranchNe   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        illegal_op = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = SRCB_SHIMM;
                state_d = decode_target(dec_class);
            end
            S_MEMADR: begin
                AluSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = (class_q == CL_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC: begin
                AluSrcA = 1'b1;
                ALUOp   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                AluSrcA  = 1'b1;
                ALUOp    = ALUOP_SUB;
                PCSrc    = PCSRC_ALUOUT;
                Branch   = (class_q == CL_BEQ);
                BranchNe = (class_q == CL_BNE);
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                AluSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                PCSrc   = PCSRC_JUMP;
                PCWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: begin
                illegal_op = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                // Unused encodings recover to FETCH with all outputs low.
                state_d = S_FETCH;
            end
        endcase

        // Reset holds every enable low, including the FETCH read request.
        if (rst) begin
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            RegWrite   = 1'b0;
            MemWrite   = 1'b0;
            Branch     = 1'b0;
            BranchNe   = 1'b0;
            MemRead    = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed testbench for mc_ctrl_fsm. Two instances share inputs: dut has
// bne enabled, dut_n has it disabled. Inputs change on the falling edge and
// outputs are sampled 1 time unit later.
module tb_mc_ctrl_fsm;

    logic       clk;
    logic       rst;
    logic [5:0] OP;
    logic       mem_ready;

    logic       IorD, AluSrcA, IRWrite, PCWrite, RegDst, MemtoReg, RegWrite;
    logic       Branch, BranchNe, MemRead, MemWrite, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSrc;
    logic [3:0] state_o;

    logic       IorD_n, AluSrcA_n, IRWrite_n, PCWrite_n, RegDst_n, MemtoReg_n, RegWrite_n;
    logic       Branch_n, BranchNe_n, MemRead_n, MemWrite_n, illegal_op_n;
    logic [1:0] ALUSrcB_n, ALUOp_n, PCSrc_n;
    logic [3:0] state_o_n;

    int checks   = 0;
    int failures = 0;

    mc_ctrl_fsm dut (
        .clk(clk), .rst(rst), .OP(OP), .mem_ready(mem_ready),
        .IorD(IorD), .AluSrcA(AluSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSrc(PCSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .Branch(Branch),
        .BranchNe(BranchNe), .MemRead(MemRead), .MemWrite(MemWrite),
        .illegal_op(illegal_op), .state_o(state_o)
    );

    mc_ctrl_fsm #(.EN_BNE(1'b0)) dut_n (
        .clk(clk), .rst(rst), .OP(OP), .mem_ready(mem_ready),
        .IorD(IorD_n), .AluSrcA(AluSrcA_n), .ALUSrcB(ALUSrcB_n), .ALUOp(ALUOp_n),
        .PCSrc(PCSrc_n), .IRWrite(IRWrite_n), .PCWrite(PCWrite_n), .RegDst(RegDst_n),
        .MemtoReg(MemtoReg_n), .RegWrite(RegWrite_n), .Branch(Branch_n),
        .BranchNe(BranchNe_n), .MemRead(MemRead_n), .MemWrite(MemWrite_n),
        .illegal_op(illegal_op_n), .state_o(state_o_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs for the coming rising edge and let outputs settle.
    task automatic drive(input logic [5:0] op, input logic rdy);
        @(negedge clk);
        OP        = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            drive(6'd35, 1'b1);
            checks++;
            if (state_o !== 4'd0 || MemRead !== 1'b0 || IRWrite !== 1'b0 ||
                PCWrite !== 1'b0 || illegal_op !== 1'b0 || RegWrite !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc=%0d state=%0d MemRead=%b IRWrite=%b PCWrite=%b ill=%b RegWrite=%b exp state=0 enables=0",
                         k, state_o, MemRead, IRWrite, PCWrite, illegal_op, RegWrite);
            end
        end
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== 4'd0 || MemRead !== 1'b1 || ALUSrcB !== 2'd1 || IRWrite !== 1'b0) begin
            failures++;
            $display("FAIL reset_release state=%0d MemRead=%b ALUSrcB=%0d IRWrite=%b exp 0/1/1/0",
                     state_o, MemRead, ALUSrcB, IRWrite);
        end
    endtask

    task automatic test_fetch_wait();
        for (int k = 0; k < 3; k++) begin
            drive(6'd0, 1'b0);
            checks++;
            if (state_o !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 || MemRead !== 1'b1) begin
                failures++;
                $display("FAIL fetch_wait cyc=%0d state=%0d IRWrite=%b PCWrite=%b MemRead=%b exp 0/0/0/1",
                         k, state_o, IRWrite, PCWrite, MemRead);
            end
        end
    endtask

    task automatic test_lw();
        logic [3:0] exp_st [0:5];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        for (int k = 0; k < 6; k++) begin
            drive(6'd35, (k < 5));
            checks++;
            if (state_o !== exp_st[k] || RegWrite !== (k == 4) || MemtoReg !== (k == 4)) begin
                failures++;
                $display("FAIL lw cyc=%0d state=%0d RegWrite=%b MemtoReg=%b exp state=%0d rw=mtr=%b",
                         k, state_o, RegWrite, MemtoReg, exp_st[k], (k == 4));
            end
            checks++;
            if (IRWrite !== (k == 0) || IorD !== (k == 3) || MemRead !== (k == 0 || k == 3 || k == 5)) begin
                failures++;
                $display("FAIL lw_ctrl cyc=%0d IRWrite=%b IorD=%b MemRead=%b", k, IRWrite, IorD, MemRead);
            end
        end
    endtask

    task automatic test_sw_wait();
        logic [3:0] exp_st [0:7];
        logic       rdy    [0:7];
        int         wr_cnt;
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
        rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        wr_cnt = 0;
        for (int k = 0; k < 8; k++) begin
            drive(6'd43, rdy[k]);
            if (MemWrite === 1'b1) wr_cnt++;
            checks++;
            if (state_o !== exp_st[k] || RegWrite !== 1'b0 ||
                MemWrite !== (k >= 3 && k <= 6) || IorD !== (k >= 3 && k <= 6)) begin
                failures++;
                $display("FAIL sw_wait cyc=%0d state=%0d MemWrite=%b IorD=%b RegWrite=%b exp state=%0d",
                         k, state_o, MemWrite, IorD, RegWrite, exp_st[k]);
            end
        end
        checks++;
        if (wr_cnt != 4) begin
            failures++;
            $display("FAIL sw_write_cycles got=%0d exp=4", wr_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_st [0:8];
        logic [5:0] ops    [0:8];
        exp_st = '{4'd0, 4'd1, 4'd6, 4'd7, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
        ops    = '{6'd0, 6'd0, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8, 6'd8};
        for (int k = 0; k < 9; k++) begin
            drive(ops[k], (k < 8));
            checks++;
            if (state_o !== exp_st[k] || RegWrite !== (k == 3 || k == 7)) begin
                failures++;
                $display("FAIL b2b_state cyc=%0d state=%0d RegWrite=%b exp state=%0d", k, state_o, RegWrite, exp_st[k]);
            end
            if (k == 2) begin
                checks++;
                if (ALUOp !== 2'd2 || AluSrcA !== 1'b1) begin
                    failures++;
                    $display("FAIL rtype_exec ALUOp=%0d AluSrcA=%b exp 2/1", ALUOp, AluSrcA);
                end
            end
            if (k == 3) begin
                checks++;
                if (RegDst !== 1'b1) begin
                    failures++;
                    $display("FAIL rtype_wb RegDst=%b exp 1", RegDst);
                end
            end
            if (k == 6) begin
                checks++;
                if (ALUSrcB !== 2'd2 || AluSrcA !== 1'b1) begin
                    failures++;
                    $display("FAIL addi_exec ALUSrcB=%0d AluSrcA=%b exp 2/1", ALUSrcB, AluSrcA);
                end
            end
            if (k == 7) begin
                checks++;
                if (RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
                    failures++;
                    $display("FAIL addi_wb RegDst=%b MemtoReg=%b exp 0/0", RegDst, MemtoReg);
                end
            end
        end
    endtask

    // OP changes after DECODE must not alter the path already chosen.
    task automatic test_latching();
        logic [3:0] exp_st [0:4];
        logic [5:0] ops    [0:4];
        exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
        ops    = '{6'd35, 6'd35, 6'd43, 6'd43, 6'd43};
        for (int k = 0; k < 5; k++) begin
            drive(ops[k], 1'b1);
            checks++;
            if (state_o !== exp_st[k]) begin
                failures++;
                $display("FAIL latch_lw cyc=%0d state=%0d exp=%0d", k, state_o, exp_st[k]);
            end
        end
        // Now in FETCH again: beq, with OP switching to bne during BRANCH.
        drive(6'd4, 1'b1);
        drive(6'd4, 1'b1);
        drive(6'd5, 1'b1);
        checks++;
        if (state_o !== 4'd8 || Branch !== 1'b1 || BranchNe !== 1'b0 ||
            PCSrc !== 2'd1 || ALUOp !== 2'd1 || AluSrcA !== 1'b1) begin
            failures++;
            $display("FAIL latch_beq state=%0d Branch=%b BranchNe=%b PCSrc=%0d ALUOp=%0d exp 8/1/0/1/1",
                     state_o, Branch, BranchNe, PCSrc, ALUOp);
        end
        drive(6'd0, 1'b0);
        checks++;
        if (state_o !== 4'd0 || Branch !== 1'b0) begin
            failures++;
            $display("FAIL latch_beq_return state=%0d Branch=%b exp 0/0", state_o, Branch);
        end
    endtask

    task automatic test_bne();
        logic [3:0] exp_st   [0:3];
        logic [3:0] exp_st_n [0:3];
        exp_st   = '{4'd0, 4'd1, 4'd8, 4'd0};
        exp_st_n = '{4'd0, 4'd1, 4'd12, 4'd0};
        for (int k = 0; k < 4; k++) begin
            drive(6'd5, (k < 3));
            checks++;
            if (state_o !== exp_st[k] || BranchNe !== (k == 2) || Branch !== 1'b0 || illegal_op !== 1'b0) begin
                failures++;
                $display("FAIL bne_en cyc=%0d state=%0d BranchNe=%b Branch=%b ill=%b exp state=%0d",
                         k, state_o, BranchNe, Branch, illegal_op, exp_st[k]);
            end
            checks++;
            if (state_o_n !== exp_st_n[k] || illegal_op_n !== (k == 2) || BranchNe_n !== 1'b0) begin
                failures++;
                $display("FAIL bne_dis cyc=%0d state=%0d ill=%b BranchNe=%b exp state=%0d",
                         k, state_o_n, illegal_op_n, BranchNe_n, exp_st_n[k]);
            end
        end
    endtask

    task automatic test_jump_illegal();
        logic [3:0] exp_j   [0:3];
        logic [3:0] exp_ill [0:3];
        exp_j   = '{4'd0, 4'd1, 4'd11, 4'd0};
        exp_ill = '{4'd0, 4'd1, 4'd12, 4'd0};
        for (int k = 0; k < 4; k++) begin
            drive(6'd2, (k < 3));
            checks++;
            if (state_o !== exp_j[k] || PCWrite !== (k == 0 || k == 2) ||
                PCSrc !== ((k == 2) ? 2'd2 : 2'd0)) begin
                failures++;
                $display("FAIL jump cyc=%0d state=%0d PCWrite=%b PCSrc=%0d exp state=%0d",
                         k, state_o, PCWrite, PCSrc, exp_j[k]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            drive(6'd63, (k < 3));
            checks++;
            if (state_o !== exp_ill[k] || illegal_op !== (k == 2) || RegWrite !== 1'b0) begin
                failures++;
                $display("FAIL illegal cyc=%0d state=%0d ill=%b RegWrite=%b exp state=%0d ill=%b",
                         k, state_o, illegal_op, RegWrite, exp_ill[k], (k == 2));
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 5; k++) begin
            drive(6'd35, 1'b1);
        end
        checks++;
        if (state_o !== 4'd4 || RegWrite !== 1'b1) begin
            failures++;
            $display("FAIL mid_reach_memwb state=%0d RegWrite=%b exp 4/1", state_o, RegWrite);
        end
        // Assert reset away from the clock edge; it must take effect at once.
        rst = 1'b1;
        #1;
        checks++;
        if (state_o !== 4'd0 || RegWrite !== 1'b0 || MemRead !== 1'b0 || MemtoReg !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset state=%0d RegWrite=%b MemRead=%b MemtoReg=%b exp 0/0/0/0",
                     state_o, RegWrite, MemRead, MemtoReg);
        end
        @(negedge clk);
        rst       = 1'b0;
        mem_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (state_o !== 4'd0 || RegWrite !== 1'b0 || MemRead !== 1'b1) begin
                failures++;
                $display("FAIL mid_resume cyc=%0d state=%0d RegWrite=%b MemRead=%b exp 0/0/1",
                         k, state_o, RegWrite, MemRead);
            end
            drive(6'd35, 1'b0);
        end
        drive(6'd2, 1'b1);
        drive(6'd2, 1'b1);
        checks++;
        if (state_o !== 4'd1 || RegWrite !== 1'b0) begin
            failures++;
            $display("FAIL mid_refetch state=%0d RegWrite=%b exp 1/0", state_o, RegWrite);
        end
        drive(6'd2, 1'b0);
        drive(6'd2, 1'b0);
        checks++;
        if (state_o !== 4'd0) begin
            failures++;
            $display("FAIL mid_done state=%0d exp 0", state_o);
        end
    endtask

    initial begin
        rst       = 1'b1;
        OP        = 6'd0;
        mem_ready = 1'b0;
        test_reset();
        test_fetch_wait();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_latching();
        test_bne();
        test_jump_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multicycle control unit for the MIPS-style datapath.
- Decodes opcode `OP` and sequences fetch, decode, execute, memory and writeback over multiple cycles.
- Supports lw, sw, R-type, beq, optional bne, addi and j.
- Adds memory wait-state handshake, illegal-opcode trap and fully decoded (latch-free) outputs. Sits between instruction register and datapath muxes/enables.

Parameters:
- OP_W, 6, opcode width
- OP_LW, 35, load word opcode
- OP_SW, 43, store word opcode
- OP_RTYPE, 0, R-type opcode
- OP_BEQ, 4, branch-equal opcode
- OP_BNE, 5, branch-not-equal opcode
- OP_ADDI, 8, add-immediate opcode
- OP_J, 2, jump opcode
- EN_BNE, 1, 1 = bne supported; 0 = OP_BNE is illegal

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- OP  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory completes access this cycle
- IorD  out  1  0 = PC address, 1 = ALUOut address
- AluSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = shifted imm
- ALUOp  out  2  0 = add, 1 = sub, 2 = funct
- PCSrc  out  2  0 = ALU result, 1 = ALUOut, 2 = jump target
- IRWrite  out  1  instruction register load
- PCWrite  out  1  unconditional PC write
- RegDst  out  1  0 = rt, 1 = rd
- MemtoReg  out  1  0 = ALUOut, 1 = memory data
- RegWrite  out  1  register file write
- Branch  out  1  beq PC write qualifier
- BranchNe  out  1  bne PC write qualifier
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- illegal_op  out  1  one-cycle pulse, unknown opcode
- state_o  out  4  current state, debug

Behaviour:
- Async reset:
  - state <= FETCH immediately on rst rise.
  - While rst = 1, all enables (IRWrite, PCWrite, RegWrite, MemWrite, Branch, BranchNe, MemRead) are forced 0 and illegal_op = 0.
  - First fetch starts on the first edge after rst falls.
- Output defaults: every output is 0 in every state unless listed below. Outputs are decoded from state; mem_ready gating is the only Mealy term.
- States (4-bit encoding, order fixed) and outputs/transitions:
  - FETCH(0): MemRead = 1, ALUSrcB = 1. IRWrite = PCWrite = mem_ready. mem_ready = 0 -> stay; 1 -> DECODE.
  - DECODE(1): ALUSrcB = 3. Next state by OP:
    - lw / sw -> MEMADR
    - R-type -> EXEC
    - beq -> BRANCH
    - bne (EN_BNE = 1) -> BRANCH
    - addi -> ADDIEX
    - j -> JUMP
    - other -> TRAP
  - MEMADR(2): AluSrcA = 1, ALUSrcB = 2. lw -> MEMRD; sw -> MEMWR.
  - MEMRD(3): IorD = 1, MemRead = 1. Wait for mem_ready, then -> MEMWB.
  - MEMWB(4): MemtoReg = 1, RegWrite = 1 -> FETCH.
  - MEMWR(5): IorD = 1, MemWrite = 1 held until mem_ready, then -> FETCH.
  - EXEC(6): AluSrcA = 1, ALUOp = 2 -> ALUWB.
  - ALUWB(7): RegDst = 1, RegWrite = 1 -> FETCH.
  - BRANCH(8): AluSrcA = 1, ALUOp = 1, PCSrc = 1. Branch = 1 if beq; BranchNe = 1 if bne -> FETCH.
  - ADDIEX(9): AluSrcA = 1, ALUSrcB = 2 -> ADDIWB.
  - ADDIWB(10): RegWrite = 1 -> FETCH.
  - JUMP(11): PCSrc = 2, PCWrite = 1 -> FETCH.
  - TRAP(12): illegal_op = 1 for exactly one cycle -> FETCH.
  - Codes 13–15: unreachable; recover to FETCH next cycle, all outputs 0.
- Opcode latching: OP is sampled into a class register at DECODE. Later states use the latched class, so OP changes after DECODE have no effect.
- Opcode priority: opcode parameters must be distinct; there is no priority resolution.
- Cycle counts, mem_ready constantly 1:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq/bne 3
  - j 3
  - illegal 3
- Each wait cycle adds one cycle.
- Reset mid-instruction aborts it. No partial write occurs after rst asserts.

Decomposition:
- Package mc_ctrl_pkg:
  - state enum/localparams (FETCH..TRAP)
  - ALUSrcB, ALUOp and PCSrc encodings
  - opcode class enum: LW, SW, RT, BEQ, BNE, ADDI, J, ILL
- Sub-module mc_op_decode: combinational OP -> class, honours EN_BNE.

Test Plan:
- rst = 1 mid-MEMWB, then release -> RegWrite drops in the same cycle; state_o = 0; FETCH resumes; no further RegWrite.
- OP = 35, mem_ready = 1 -> state_o sequence 0,1,2,3,4,0; RegWrite = 1 and MemtoReg = 1 only in state 4.
- OP = 43, mem_ready low for 3 cycles in MEMWR -> MemWrite high for 4 cycles, IorD = 1, then FETCH; RegWrite never 1.
- OP = 0 then OP = 8 back-to-back -> R-type: ALUOp = 2 in EXEC, RegDst = 1 in ALUWB. addi: ALUSrcB = 2 in ADDIEX, RegWrite = 1 and RegDst = 0 in ADDIWB.
- OP = 5 with EN_BNE = 1 -> BRANCH, BranchNe = 1, Branch = 0. With EN_BNE = 0 -> TRAP, illegal_op pulses one cycle.
- OP = 2 -> JUMP with PCSrc = 2, PCWrite = 1. OP = 63 -> illegal_op = 1 one cycle, back to FETCH. In FETCH with mem_ready = 0 -> IRWrite = PCWrite = 0.
